// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: per-core memory buses plus the shared RAM bus around the arbiter
interface mem_arbiter_if #(
  parameter int N_CORES = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [N_CORES*ADDR_W-1:0] core_mem_addr;
  logic [N_CORES*DATA_W-1:0] core_mem_data_w;
  logic [N_CORES-1:0] core_mem_read;
  logic [N_CORES-1:0] core_mem_write;
  logic [N_CORES*DATA_W-1:0] core_mem_data_r;
  logic [N_CORES-1:0] core_mem_wait;
  logic [ADDR_W-1:0] ram_mem_addr;
  logic [DATA_W-1:0] ram_mem_data_w;
  logic ram_mem_read;
  logic ram_mem_write;
  logic [DATA_W-1:0] ram_mem_data_r;
  logic ram_mem_wait;
  modport slave (
    input core_mem_addr, core_mem_data_w, core_mem_read, core_mem_write, ram_mem_data_r, ram_mem_wait,
    output core_mem_data_r, core_mem_wait, ram_mem_addr, ram_mem_data_w, ram_mem_read, ram_mem_write
  );
  modport master (
    output core_mem_addr, core_mem_data_w, core_mem_read, core_mem_write, ram_mem_data_r, ram_mem_wait,
    input core_mem_data_r, core_mem_wait, ram_mem_addr, ram_mem_data_w, ram_mem_read, ram_mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one RAM port among N_CORES cores
module mem_arbiter #(
  parameter int N_CORES = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  input logic en,
  mem_arbiter_if.slave bus
);
  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [IW-1:0] grant, grant_nx, last, last_nx, pick, cand;
  logic [N_CORES-1:0] req;
  logic busy, finish, served;
  assign req = bus.core_mem_read | bus.core_mem_write;
  assign busy = state == BUSY;
  assign served = req[grant] & ~bus.ram_mem_wait;
  assign finish = busy & (~req[grant] | ~bus.ram_mem_wait);
  assign bus.core_mem_data_r = {N_CORES{bus.ram_mem_data_r}};
  always_comb begin
    pick = grant;
    cand = '0;
    for (int k = N_CORES; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_CORES);
      pick = req[cand] ? cand : pick;
    end
  end
  always_comb begin
    bus.ram_mem_addr = busy ? bus.core_mem_addr[int'(grant)*ADDR_W +: ADDR_W] : '0;
    bus.ram_mem_data_w = busy ? bus.core_mem_data_w[int'(grant)*DATA_W +: DATA_W] : '0;
    bus.ram_mem_read = busy & bus.core_mem_read[grant] & ~bus.core_mem_write[grant];
    bus.ram_mem_write = busy & bus.core_mem_write[grant];
    bus.core_mem_wait = req;
    bus.core_mem_wait[grant] = busy ? bus.ram_mem_wait : req[grant];
  end
  always_comb begin
    state_nx = !en ? state : busy ? (finish ? IDLE : BUSY) : (|req ? BUSY : IDLE);
    grant_nx = (en && !busy && |req) ? pick : grant;
    last_nx = (en && busy && served) ? grant : last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last <= IW'(N_CORES - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last <= last_nx;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int N = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  logic clk = 0;
  logic rst = 1;
  logic en = 1;
  logic ram_wait = 0;
  logic [N-1:0] rd = '0, wr = '0, hold = '0, done = '0;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];
  logic [31:0] ram [512];
  logic [31:0] mm [512];
  int checks = 0;
  int errors = 0;
  int owner = -1, last = N - 1, owner_nx = -1, last_nx = N - 1;
  int order [$];
  mem_arbiter_if #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_arbiter #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
  always #5 clk = ~clk;
  assign bus.core_mem_read = rd;
  assign bus.core_mem_write = wr;
  assign bus.ram_mem_wait = ram_wait;
  assign bus.ram_mem_data_r = ram[bus.ram_mem_addr[10:2]];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.core_mem_addr[i*AW +: AW] = addr[i];
      bus.core_mem_data_w[i*DW +: DW] = wdat[i];
    end
  end
  function automatic logic [31:0] seed(int i);
    return (i == 100) ? 32'd1 : 32'h9E3779B9 * i + 32'h1234;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = seed(i);
    forever begin
      @(posedge clk);
      if (bus.ram_mem_write && !bus.ram_mem_wait) ram[bus.ram_mem_addr[10:2]] = bus.ram_mem_data_w;
    end
  end
  always @(posedge clk) begin
    owner <= owner_nx;
    last <= last_nx;
  end
  initial begin
    logic [N-1:0] rq, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic er, ewr;
    for (int i = 0; i < 512; i++) mm[i] = seed(i);
    forever begin
      @(negedge clk);
      rq = rd | wr;
      ew = rq;
      ea = '0;
      ed = '0;
      er = 0;
      ewr = 0;
      if (owner >= 0) begin
        ea = addr[owner];
        ed = wdat[owner];
        ewr = wr[owner];
        er = rd[owner] & ~wr[owner];
        ew[owner] = ram_wait;
      end
      chk("ram_read", bus.ram_mem_read, er);
      chk("ram_write", bus.ram_mem_write, ewr);
      chk("ram_addr", bus.ram_mem_addr, ea);
      chk("ram_data_w", bus.ram_mem_data_w, ed);
      chk("core_wait", bus.core_mem_wait, ew);
      for (int i = 0; i < N; i++) chk("data_r_bcast", bus.core_mem_data_r[i*DW +: DW], bus.ram_mem_data_r);
      if (owner >= 0 && rq[owner] && !ram_wait) begin
        if (er) chk("read_data", bus.core_mem_data_r[owner*DW +: DW], mm[ea[10:2]]);
        if (ewr) mm[ea[10:2]] = ed;
      end
      done = rq & ~ew;
      owner_nx = owner;
      last_nx = last;
      if (rst) begin
        owner_nx = -1;
        last_nx = N - 1;
      end else if (en && owner < 0) begin
        for (int k = 1; k <= N; k++)
          if (owner_nx < 0 && rq[(last + k) % N]) owner_nx = (last + k) % N;
      end else if (en) begin
        if (rq[owner] && !ram_wait) last_nx = owner;
        if (!rq[owner] || !ram_wait) owner_nx = -1;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (done[i] && !hold[i]) begin
        rd[i] = 0;
        wr[i] = 0;
      end
  endtask
  task automatic do_reset();
    rst = 1;
    en = 1;
    rd = '0;
    wr = '0;
    hold = '0;
    ram_wait = 0;
    cyc();
    cyc();
    rst = 0;
  endtask
  task automatic new_req(input int i);
    int k;
    k = $urandom_range(0, 2);
    rd[i] = k != 1;
    wr[i] = k != 0;
    addr[i] = 32'($urandom_range(0, 511)) << 2;
    wdat[i] = $urandom;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdat[i] = '0;
    end
    do_reset();
    chk("reset_read", bus.ram_mem_read, 0);
    chk("reset_wait", bus.core_mem_wait, 0);
    rd[0] = 1;
    addr[0] = 400;
    @(negedge clk);
    chk("s1_c0_wait", bus.core_mem_wait, 3'b001);
    chk("s1_c0_read", bus.ram_mem_read, 0);
    cyc();
    @(negedge clk);
    chk("s1_c1_read", bus.ram_mem_read, 1);
    chk("s1_c1_addr", bus.ram_mem_addr, 400);
    chk("s1_c1_wait", bus.core_mem_wait, 3'b000);
    chk("s1_c1_data", bus.core_mem_data_r[0 +: DW], 1);
    cyc();
    @(negedge clk);
    chk("s1_c2_read", bus.ram_mem_read, 0);
    cyc();
    do_reset();
    rd[0] = 1;
    addr[0] = 800;
    wr[1] = 1;
    addr[1] = 1200;
    wdat[1] = 32'h1ABCDEF0;
    @(negedge clk);
    chk("s2_c0_wait", bus.core_mem_wait, 3'b011);
    cyc();
    @(negedge clk);
    chk("s2_c1_read", bus.ram_mem_read, 1);
    chk("s2_c1_addr", bus.ram_mem_addr, 800);
    chk("s2_c1_wait", bus.core_mem_wait, 3'b010);
    cyc();
    @(negedge clk);
    chk("s2_c2_wait", bus.core_mem_wait, 3'b010);
    chk("s2_c2_write", bus.ram_mem_write, 0);
    cyc();
    @(negedge clk);
    chk("s2_c3_write", bus.ram_mem_write, 1);
    chk("s2_c3_addr", bus.ram_mem_addr, 1200);
    chk("s2_c3_data", bus.ram_mem_data_w, 32'h1ABCDEF0);
    chk("s2_c3_wait", bus.core_mem_wait, 3'b000);
    cyc();
    @(negedge clk);
    chk("s2_ram300", ram[300], 32'h1ABCDEF0);
    do_reset();
    for (int i = 0; i < N; i++) addr[i] = 64 + 4 * i;
    rd = '1;
    hold = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.ram_mem_read && !bus.ram_mem_wait)
        for (int i = 0; i < N; i++) if (bus.ram_mem_addr == addr[i]) order.push_back(i);
      cyc();
    end
    chk("rr_count", order.size(), 6);
    for (int j = 0; j < 6; j++) if (j < order.size()) chk("rr_order", order[j], j % 3);
    do_reset();
    wr[1] = 1;
    addr[1] = 2000;
    wdat[1] = 32'hCAFE0001;
    @(negedge clk);
    chk("s4_c0_wait", bus.core_mem_wait, 3'b010);
    cyc();
    ram_wait = 1;
    @(negedge clk);
    chk("s4_c1_wait", bus.core_mem_wait, 3'b010);
    chk("s4_c1_write", bus.ram_mem_write, 1);
    chk("s4_c1_addr", bus.ram_mem_addr, 2000);
    cyc();
    rd[0] = 1;
    addr[0] = 4;
    @(negedge clk);
    chk("s4_c2_wait", bus.core_mem_wait, 3'b011);
    chk("s4_c2_addr", bus.ram_mem_addr, 2000);
    chk("s4_c2_data", bus.ram_mem_data_w, 32'hCAFE0001);
    cyc();
    @(negedge clk);
    chk("s4_c3_addr", bus.ram_mem_addr, 2000);
    cyc();
    ram_wait = 0;
    @(negedge clk);
    chk("s4_c4_wait", bus.core_mem_wait, 3'b001);
    chk("s4_c4_write", bus.ram_mem_write, 1);
    cyc();
    @(negedge clk);
    chk("s4_c5_idle", {bus.ram_mem_read, bus.ram_mem_write}, 0);
    cyc();
    @(negedge clk);
    chk("s4_c6_read", bus.ram_mem_read, 1);
    chk("s4_c6_addr", bus.ram_mem_addr, 4);
    chk("s4_ram500", ram[500], 32'hCAFE0001);
    cyc();
    do_reset();
    rd[0] = 1;
    addr[0] = 8;
    hold[0] = 1;
    @(negedge clk);
    chk("s5_c0_wait", bus.core_mem_wait, 3'b001);
    cyc();
    en = 0;
    wr[1] = 1;
    addr[1] = 12;
    wdat[1] = 32'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("s5_hold_read", bus.ram_mem_read, 1);
      chk("s5_hold_addr", bus.ram_mem_addr, 8);
      chk("s5_hold_wait", bus.core_mem_wait, 3'b010);
      cyc();
    end
    en = 1;
    @(negedge clk);
    chk("s5_c5_read", bus.ram_mem_read, 1);
    cyc();
    @(negedge clk);
    chk("s5_c6_idle", {bus.ram_mem_read, bus.ram_mem_write}, 0);
    cyc();
    @(negedge clk);
    chk("s5_c7_write", bus.ram_mem_write, 1);
    chk("s5_c7_addr", bus.ram_mem_addr, 12);
    cyc();
    do_reset();
    rd[1] = 1;
    addr[1] = 16;
    ram_wait = 1;
    @(negedge clk);
    chk("s6_c0_wait", bus.core_mem_wait, 3'b010);
    cyc();
    @(negedge clk);
    chk("s6_c1_read", bus.ram_mem_read, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("s6_c2_read", bus.ram_mem_read, 1);
    cyc();
    rst = 0;
    rd[0] = 1;
    addr[0] = 20;
    @(negedge clk);
    chk("s6_c3_read", bus.ram_mem_read, 0);
    chk("s6_c3_wait", bus.core_mem_wait, 3'b011);
    cyc();
    ram_wait = 0;
    @(negedge clk);
    chk("s6_c4_read", bus.ram_mem_read, 1);
    chk("s6_c4_addr", bus.ram_mem_addr, 20);
    chk("s6_c4_wait", bus.core_mem_wait, 3'b010);
    cyc();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      ram_wait = $urandom_range(0, 3) == 0;
      en = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 99) == 0;
      for (int i = 0; i < N; i++) begin
        if (rd[i] || wr[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 1) == 0) begin
              rd[i] = 0;
              wr[i] = 0;
            end else new_req(i);
          end else if ($urandom_range(0, 63) == 0) begin
            rd[i] = 0;
            wr[i] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) new_req(i);
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that lets N_CORES cores share one data memory port.
- Sits between the cores' mem_* data ports and a single RAM instance (DUMMY_RAM or the future shared memory).
- Uses the same mem_read/mem_write/mem_wait handshake on both sides, so cores and RAM connect unmodified.

Parameters:
- N_CORES, 2, number of requesting cores (2..8).
- DATA_W, 32, data width.
- ADDR_W, 32, data address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, arbiter state and pointer hold.
- core_mem_addr  in  N_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_mem_data_w  in  N_CORES*DATA_W  per-core write data.
- core_mem_read  in  N_CORES  per-core read request.
- core_mem_write  in  N_CORES  per-core write request.
- core_mem_data_r  out  N_CORES*DATA_W  per-core read data.
- core_mem_wait  out  N_CORES  per-core stall.
- ram_mem_addr  out  ADDR_W  address to RAM.
- ram_mem_data_w  out  DATA_W  write data to RAM.
- ram_mem_read  out  1  read strobe to RAM.
- ram_mem_write  out  1  write strobe to RAM.
- ram_mem_data_r  in  DATA_W  RAM read data.
- ram_mem_wait  in  1  RAM stall.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. All state updates on posedge clk. rst has priority over en.
- Handshake, both sides: a requester holds read or write, addr and data_w stable until it samples wait=0. The cycle with request=1 and wait=0 is the completion cycle; read data is valid on data_r in that cycle.
- Per-core request: req[i] = core_mem_read[i] | core_mem_write[i]. Read and write asserted together is treated as a write.
- State: IDLE, BUSY. Registers: grant (index), last (index of the last served core).
- Reset values: state=IDLE, last=N_CORES-1 (core 0 wins first), grant=0.
- IDLE:
  - RAM outputs are driven 0.
  - core_mem_wait[i] = req[i].
  - If any req, grant = first requesting core in the order last+1, last+2, ... (mod N_CORES), and the state moves to BUSY. Otherwise IDLE holds.
- BUSY:
  - ram_mem_* are driven combinationally from the granted core's inputs.
  - core_mem_wait[grant] = ram_mem_wait.
  - All other requesting cores see wait=1; non-requesting cores see 0.
  - Completion (req[grant] & !ram_mem_wait): at the edge, last=grant and state goes to IDLE.
  - Granted core drops its request before completion (protocol violation): ram strobes fall to 0 immediately, state goes to IDLE, last is unchanged.
- core_mem_data_r: ram_mem_data_r is broadcast to every core's slot; only the granted core's completion cycle is meaningful.
- Latency: minimum 2 cycles per access (arbitration cycle + RAM cycle). With zero-wait RAM, back-to-back requests from one core complete every 2 cycles.
- Fairness: with K cores continuously requesting, each is served once per K grants. No core waits more than N_CORES-1 transactions.
- en=0: state, grant and last hold. Outputs keep following the combinational rules above.
- rst mid-transaction: the access is abandoned, strobes drop in the next cycle (state IDLE), and pointers reset. The RAM must tolerate strobe removal.
- Widths: index registers are $clog2(N_CORES) bits. Pointer wrap is modulo N_CORES, not a power of two.

Test Plan:
- Single read, zero-wait RAM, N_CORES=2, ram.data[100]=1: core0 read addr 400.
  - Cycle 0: wait0=1.
  - Cycle 1: ram_mem_read=1, ram_mem_addr=400, wait0=0, core0 data_r=1.
  - Cycle 2: state IDLE.
- Simultaneous requests from reset: core0 read addr 800, core1 write addr 1200 data 0x1ABCDEF0.
  - core0 served first; wait1 stays 1 throughout.
  - core1 completes 2 cycles later; ram.data[300]=0x1ABCDEF0.
- Round-robin, N_CORES=3: all cores request continuously for 6 grants.
  - Grant order 0,1,2,0,1,2; no core starves.
- RAM stalls ram_mem_wait=1 for 3 cycles during core1 write:
  - wait1 mirrors the stall; ram_mem_addr/data_w stay stable; completion occurs in the 4th BUSY cycle.
  - A core0 request arriving mid-stall is not granted until after completion.
- en=0 for 4 cycles while BUSY with RAM wait=0:
  - state does not leave BUSY and last is not updated.
  - After en=1, the next completion advances the pointer normally.
- rst asserted in 2nd BUSY cycle of a stalled read:
  - Next cycle ram_mem_read=0, state IDLE.
  - A subsequent simultaneous request from cores 0 and 1 grants core 0.
